// File: rtl/lockstep_pkg.sv
// Shared definitions for the lockstep checker: FSM state encoding (also used by
// benches) and the pairwise core-agreement rule.
package lockstep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_DONE    = 3'd2,
        ST_TIMEOUT = 3'd3,
        ST_FAULT   = 3'd4
    } state_e;

    localparam logic [2:0] STATE_IDLE    = 3'd0;
    localparam logic [2:0] STATE_RUN     = 3'd1;
    localparam logic [2:0] STATE_DONE    = 3'd2;
    localparam logic [2:0] STATE_TIMEOUT = 3'd3;
    localparam logic [2:0] STATE_FAULT   = 3'd4;

    // Write data only matters when at least one of the two cores is writing.
    function automatic logic cores_agree(input logic we_a,
                                         input logic we_b,
                                         input logic addr_eq,
                                         input logic data_eq,
                                         input logic iaddr_eq);
        return (we_a == we_b) && addr_eq && iaddr_eq && (data_eq || (!we_a && !we_b));
    endfunction

endpackage

// File: rtl/majority_voter.sv
// Combinational N-way comparator: picks the lowest-index majority core (TMR) or
// flags any disagreement between the two cores (DMR, detect-only).
module majority_voter
    import lockstep_pkg::*;
#(
    parameter int NUM_CORES = 3,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic [NUM_CORES-1:0]         we,
    input  logic [NUM_CORES*ADDR_W-1:0]  addr,
    input  logic [NUM_CORES*DATA_W-1:0]  data,
    input  logic [NUM_CORES*ADDR_W-1:0]  iaddr,
    output logic [$clog2(NUM_CORES)-1:0] winner,
    output logic [NUM_CORES-1:0]         mismatch,
    output logic                         no_majority
);

    localparam int WIN_W = $clog2(NUM_CORES);

    logic [NUM_CORES-1:0][NUM_CORES-1:0] agree;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        agree = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            for (int j = 0; j < NUM_CORES; j++) begin
                agree[i][j] = cores_agree(we[i], we[j],
                    addr[i*ADDR_W +: ADDR_W]  == addr[j*ADDR_W +: ADDR_W],
                    data[i*DATA_W +: DATA_W]  == data[j*DATA_W +: DATA_W],
                    iaddr[i*ADDR_W +: ADDR_W] == iaddr[j*ADDR_W +: ADDR_W]);
            end
        end
    end

    if (NUM_CORES == 2) begin : g_dmr
        assign winner      = '0;
        assign no_majority = 1'b0;
        assign mismatch    = {NUM_CORES{~agree[0][1]}};
    end else begin : g_tmr
        always_comb begin
            int   votes;
            logic found;
            winner = '0;
            found  = 1'b0;
            votes  = 0;
            for (int i = 0; i < NUM_CORES; i++) begin
                votes = 0;
                for (int j = 0; j < NUM_CORES; j++) begin
                    if (agree[i][j]) votes++;
                end
                if (!found && votes > NUM_CORES / 2) begin
                    found  = 1'b1;
                    winner = WIN_W'(i);
                end
            end
            no_majority = ~found;
            mismatch    = found ? ~agree[winner] : '1;
        end
    end

endmodule

// File: rtl/lockstep_checker.sv
// N-way lockstep checker: registered majority-voted write port, saturating
// mismatch counter, sticky fault and a run watchdog FSM.
module lockstep_checker
    import lockstep_pkg::*;
#(
    parameter int NUM_CORES   = 3,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ERR_W       = 8,
    parameter int TIMEOUT     = 1000,
    parameter int FAULT_LIMIT = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        enable_i,
    input  logic [NUM_CORES-1:0]        core_we_i,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr_i,
    input  logic [NUM_CORES*DATA_W-1:0] core_data_i,
    input  logic [NUM_CORES*ADDR_W-1:0] core_iaddr_i,
    input  logic                        done_flag_i,
    output logic                        voted_we_o,
    output logic [ADDR_W-1:0]           voted_addr_o,
    output logic [DATA_W-1:0]           voted_data_o,
    output logic [NUM_CORES-1:0]        mismatch_o,
    output logic [ERR_W-1:0]            err_count_o,
    output logic                        fault_o,
    output logic                        done_o,
    output logic                        timeout_o,
    output logic [2:0]                  state_o
);

    localparam int               WIN_W        = $clog2(NUM_CORES);
    localparam int               CYC_W        = $clog2(TIMEOUT);
    localparam logic [CYC_W-1:0] CYC_LAST     = CYC_W'(TIMEOUT - 1);
    localparam logic [ERR_W-1:0] ERR_LIMIT    = ERR_W'(FAULT_LIMIT);

    state_e             state_q, state_d;
    logic [CYC_W-1:0]   cyc_q;
    logic [ERR_W-1:0]   err_q, err_next;
    logic [WIN_W-1:0]   winner;
    logic [NUM_CORES-1:0] mismatch_c;
    logic               no_majority;
    logic               in_run;

    majority_voter #(
        .NUM_CORES (NUM_CORES),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W)
    ) u_voter (
        .we          (core_we_i),
        .addr        (core_addr_i),
        .data        (core_data_i),
        .iaddr       (core_iaddr_i),
        .winner      (winner),
        .mismatch    (mismatch_c),
        .no_majority (no_majority)
    );

    assign in_run = (state_q == ST_RUN);

    always_comb begin
        err_next = err_q;
        if (in_run && (|mismatch_c) && (err_q != '1)) err_next = err_q + 1'b1;
    end

    // Same-edge priority inside RUN: fault, then done, then timeout, then disable.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable_i) state_d = ST_RUN;
            ST_RUN: begin
                if (no_majority || (err_next >= ERR_LIMIT)) state_d = ST_FAULT;
                else if (done_flag_i)                       state_d = ST_DONE;
                else if (cyc_q == CYC_LAST)                 state_d = ST_TIMEOUT;
                else if (!enable_i)                         state_d = ST_IDLE;
            end
            ST_DONE, ST_TIMEOUT, ST_FAULT: state_d = state_q;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            cyc_q        <= '0;
            err_q        <= '0;
            voted_we_o   <= 1'b0;
            voted_addr_o <= '0;
            voted_data_o <= '0;
            mismatch_o   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_next;
            cyc_q   <= (in_run && state_d == ST_RUN) ? cyc_q + 1'b1 : '0;
            if (in_run) begin
                voted_we_o   <= core_we_i[winner];
                voted_addr_o <= core_addr_i[winner*ADDR_W +: ADDR_W];
                voted_data_o <= core_data_i[winner*DATA_W +: DATA_W];
                mismatch_o   <= mismatch_c;
            end else begin
                voted_we_o   <= 1'b0;
                voted_addr_o <= '0;
                voted_data_o <= '0;
                mismatch_o   <= '0;
            end
        end
    end

    assign err_count_o = err_q;
    assign state_o     = state_q;
    assign fault_o     = (state_q == ST_FAULT);
    assign done_o      = (state_q == ST_DONE);
    assign timeout_o   = (state_q == ST_TIMEOUT);

endmodule

// File: tb/tb_lockstep_checker.sv
// Scoreboard bench for lockstep_checker: a TMR instance and a DMR instance,
// directed vectors push expected outputs, per-instance monitors pop and compare.
module tb_lockstep_checker;
    import lockstep_pkg::*;

    typedef struct packed {
        logic [2:0]  st;
        logic        vwe;
        logic [31:0] va;
        logic [31:0] vd;
        logic [2:0]  mm;
        logic [7:0]  err;
        logic        fault;
        logic        done;
        logic        tmo;
    } obs_t;

    typedef struct {
        string name;
        obs_t  v;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // TMR instance signals
    logic        t_rst, t_en, t_done;
    logic [2:0]  t_we;
    logic [95:0] t_addr, t_data, t_iaddr;
    logic        t_vwe, t_fault, t_done_o, t_tmo;
    logic [31:0] t_va, t_vd;
    logic [2:0]  t_mm, t_st;
    logic [7:0]  t_err;

    // DMR instance signals
    logic        d_rst, d_en, d_done;
    logic [1:0]  d_we;
    logic [63:0] d_addr, d_data, d_iaddr;
    logic        d_vwe, d_fault, d_done_o, d_tmo;
    logic [31:0] d_va, d_vd;
    logic [1:0]  d_mm;
    logic [2:0]  d_st;
    logic [7:0]  d_err;

    lockstep_checker #(
        .NUM_CORES(3), .ADDR_W(32), .DATA_W(32), .ERR_W(8), .TIMEOUT(20), .FAULT_LIMIT(4)
    ) dut_tmr (
        .clk_i(clk), .rst_ni(t_rst), .enable_i(t_en),
        .core_we_i(t_we), .core_addr_i(t_addr), .core_data_i(t_data), .core_iaddr_i(t_iaddr),
        .done_flag_i(t_done),
        .voted_we_o(t_vwe), .voted_addr_o(t_va), .voted_data_o(t_vd),
        .mismatch_o(t_mm), .err_count_o(t_err), .fault_o(t_fault),
        .done_o(t_done_o), .timeout_o(t_tmo), .state_o(t_st)
    );

    lockstep_checker #(
        .NUM_CORES(2), .ADDR_W(32), .DATA_W(32), .ERR_W(8), .TIMEOUT(1000), .FAULT_LIMIT(2)
    ) dut_dmr (
        .clk_i(clk), .rst_ni(d_rst), .enable_i(d_en),
        .core_we_i(d_we), .core_addr_i(d_addr), .core_data_i(d_data), .core_iaddr_i(d_iaddr),
        .done_flag_i(d_done),
        .voted_we_o(d_vwe), .voted_addr_o(d_va), .voted_data_o(d_vd),
        .mismatch_o(d_mm), .err_count_o(d_err), .fault_o(d_fault),
        .done_o(d_done_o), .timeout_o(d_tmo), .state_o(d_st)
    );

    exp_t q_t[$];
    exp_t q_d[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got st=%0d we=%0b a=%h d=%h mm=%b err=%0d f/d/t=%b%b%b, expected st=%0d we=%0b a=%h d=%h mm=%b err=%0d f/d/t=%b%b%b",
                     name, act.st, act.vwe, act.va, act.vd, act.mm, act.err, act.fault, act.done, act.tmo,
                     exp.st, exp.vwe, exp.va, exp.vd, exp.mm, exp.err, exp.fault, exp.done, exp.tmo);
        end
    endtask

    // Expected flags follow from the expected state alone.
    function automatic obs_t mk(input logic [2:0] st, input logic vwe, input logic [31:0] va,
                                input logic [31:0] vd, input logic [2:0] mm, input logic [7:0] err);
        obs_t o;
        o = {st, vwe, va, vd, mm, err, st == STATE_FAULT, st == STATE_DONE, st == STATE_TIMEOUT};
        return o;
    endfunction

    // Push the expectation for the inputs currently driven, then advance one cycle.
    task automatic step(input bit dmr, input string name, input logic [2:0] st, input logic vwe,
                        input logic [31:0] va, input logic [31:0] vd, input logic [2:0] mm,
                        input logic [7:0] err);
        exp_t e;
        e.name = name;
        e.v    = mk(st, vwe, va, vd, mm, err);
        if (dmr) q_d.push_back(e);
        else     q_t.push_back(e);
        @(negedge clk);
    endtask

    task automatic t_all(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [31:0] i);
        t_we    = {3{w}};
        t_addr  = {3{a}};
        t_data  = {3{d}};
        t_iaddr = {3{i}};
    endtask

    task automatic d_all(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [31:0] i);
        d_we    = {2{w}};
        d_addr  = {2{a}};
        d_data  = {2{d}};
        d_iaddr = {2{i}};
    endtask

    initial begin : mon_tmr
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_t.size() > 0) begin
                e = q_t.pop_front();
                check(e.name, {t_st, t_vwe, t_va, t_vd, t_mm, t_err, t_fault, t_done_o, t_tmo}, e.v);
            end
        end
    end

    initial begin : mon_dmr
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_d.size() > 0) begin
                e = q_d.pop_front();
                check(e.name, {d_st, d_vwe, d_va, d_vd, 1'b0, d_mm, d_err, d_fault, d_done_o, d_tmo}, e.v);
            end
        end
    end

    localparam logic [31:0] A = 32'h100;
    localparam logic [31:0] D = 32'd42;
    localparam logic [31:0] I = 32'h10;

    initial begin
        t_rst = 1'b0; t_en = 1'b0; t_done = 1'b0; t_all(1'b0, '0, '0, '0);
        d_rst = 1'b0; d_en = 1'b0; d_done = 1'b0; d_all(1'b0, '0, '0, '0);
        @(negedge clk);

        // TMR: voting, mismatch counting, no-majority fault, reset from FAULT
        step(0, "t_reset", STATE_IDLE, 0, 0, 0, 3'b000, 0);
        t_rst = 1'b1; t_en = 1'b1; t_all(1'b1, A, D, I);
        step(0, "t_enter_run", STATE_RUN, 0, 0, 0, 3'b000, 0);
        step(0, "t_all_agree", STATE_RUN, 1, A, D, 3'b000, 0);
        t_data[32 +: 32] = 32'd43;
        step(0, "t_core1_data", STATE_RUN, 1, A, D, 3'b010, 1);
        t_all(1'b0, A, D, I); t_data[64 +: 32] = 32'd7;
        step(0, "t_nowrite_data_ignored", STATE_RUN, 0, A, D, 3'b000, 1);
        t_all(1'b0, A, D, I); t_we[2] = 1'b1;
        step(0, "t_core2_we", STATE_RUN, 0, A, D, 3'b100, 2);
        t_all(1'b1, A, D, I); t_iaddr = {32'd3, 32'd2, 32'd1};
        step(0, "t_no_majority", STATE_FAULT, 1, A, D, 3'b111, 3);
        t_all(1'b1, A, D, I); t_done = 1'b1;
        step(0, "t_fault_terminal", STATE_FAULT, 0, 0, 0, 3'b000, 3);
        t_done = 1'b0; t_rst = 1'b0;
        step(0, "t_reset_from_fault", STATE_IDLE, 0, 0, 0, 3'b000, 0);

        // TMR: watchdog, with a core-0 address fault voted out along the way
        t_rst = 1'b1;
        step(0, "t_run2_entry", STATE_RUN, 0, 0, 0, 3'b000, 0);
        for (int k = 1; k < 20; k++) begin
            t_all(1'b1, A, D, I);
            if (k == 5) begin
                t_addr[0 +: 32] = 32'h200;
                step(0, "t_core0_addr", STATE_RUN, 1, A, D, 3'b001, 1);
            end else begin
                step(0, "t_run_cycle", STATE_RUN, 1, A, D, 3'b000, (k > 5) ? 8'd1 : 8'd0);
            end
        end
        t_all(1'b1, A, D, I);
        step(0, "t_timeout_edge", STATE_TIMEOUT, 1, A, D, 3'b000, 1);
        t_done = 1'b1;
        step(0, "t_timeout_terminal", STATE_TIMEOUT, 0, 0, 0, 3'b000, 1);
        t_done = 1'b0;

        // TMR: RUN->IDLE keeps err_count; done and fault on the same edge
        t_rst = 1'b0;
        step(0, "t_reset3", STATE_IDLE, 0, 0, 0, 3'b000, 0);
        t_rst = 1'b1;
        step(0, "t_run3_entry", STATE_RUN, 0, 0, 0, 3'b000, 0);
        t_data[64 +: 32] = 32'd5;
        step(0, "t_core2_data", STATE_RUN, 1, A, D, 3'b100, 1);
        t_all(1'b1, A, D, I); t_en = 1'b0;
        step(0, "t_disable", STATE_IDLE, 1, A, D, 3'b000, 1);
        t_en = 1'b1;
        step(0, "t_reenable", STATE_RUN, 0, 0, 0, 3'b000, 1);
        t_done = 1'b1; t_iaddr = {32'd3, 32'd2, 32'd1};
        step(0, "t_done_and_fault", STATE_FAULT, 1, A, D, 3'b111, 2);
        t_done = 1'b0; t_all(1'b1, A, D, I);

        // TMR: clean completion
        t_rst = 1'b0;
        step(0, "t_reset4", STATE_IDLE, 0, 0, 0, 3'b000, 0);
        t_rst = 1'b1;
        step(0, "t_run4_entry", STATE_RUN, 0, 0, 0, 3'b000, 0);
        t_done = 1'b1;
        step(0, "t_done", STATE_DONE, 1, A, D, 3'b000, 0);
        t_done = 1'b0; t_en = 1'b0;
        step(0, "t_done_terminal", STATE_DONE, 0, 0, 0, 3'b000, 0);

        // DMR: detect-only, FAULT_LIMIT = 2
        d_all(1'b1, A, D, I);
        step(1, "d_reset", STATE_IDLE, 0, 0, 0, 3'b000, 0);
        d_rst = 1'b1; d_en = 1'b1;
        step(1, "d_enter_run", STATE_RUN, 0, 0, 0, 3'b000, 0);
        step(1, "d_agree", STATE_RUN, 1, A, D, 3'b000, 0);
        d_addr[32 +: 32] = 32'h104;
        step(1, "d_addr_mismatch1", STATE_RUN, 1, A, D, 3'b011, 1);
        d_all(1'b1, A, D, I);
        step(1, "d_agree2", STATE_RUN, 1, A, D, 3'b000, 1);
        d_addr[0 +: 32] = 32'h108;
        step(1, "d_addr_mismatch2", STATE_FAULT, 1, 32'h108, D, 3'b011, 2);
        d_all(1'b1, A, D, I); d_done = 1'b1;
        step(1, "d_done_ignored", STATE_FAULT, 0, 0, 0, 3'b000, 2);
        d_done = 1'b0;

        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (q_t.size() != 0 || q_d.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d/%0d entries left, expected 0/0", q_t.size(), q_d.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
